// File: rtl/spi_master_ctrl.sv
// SPI master with CPOL/CPHA modes, SCLK divider and multi-word chip-select chaining.
// Optional SPI_MASTER_CTRL_LOOPBACK_EN adds cfg_loopback (sample internal mosi, no CS).
module spi_master_ctrl #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 2,
    parameter int DIV_W  = 8,
    localparam int SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic [DIV_W-1:0]  cfg_div,
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
    input  logic              cfg_loopback,
`endif
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  tx_cs_sel,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int EDGES = 2 * DATA_W;
    localparam int EW    = $clog2(EDGES + 1);

    typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, CHAIN} state_t;

    state_t             state;
    logic [DIV_W-1:0]   cnt;
    logic [DIV_W-1:0]   div_q;
    logic [EW-1:0]      ecnt;
    logic [DATA_W-1:0]  tx_sh;
    logic [DATA_W-1:0]  rx_sh;
    logic [SEL_W-1:0]   sel_q;
    logic               last_q;
    logic               cpha_q;
    logic               sclk_q;
    logic               hp_done;
    logic               leading;
    logic               final_edge;
    logic               din;
    logic               lb_in;

`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
    logic lb_q;
    assign lb_in = cfg_loopback;
    assign din   = lb_q ? mosi : miso;
`else
    assign lb_in = 1'b0;
    assign din   = miso;
`endif

    function automatic logic [NUM_CS-1:0] cs_dec(input logic [SEL_W-1:0] s);
        logic [NUM_CS-1:0] m;
        m = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(s) == i) m[i] = 1'b0;
        return m;
    endfunction

    assign hp_done    = (cnt == div_q);
    assign leading    = ~ecnt[0];
    assign final_edge = (ecnt == EW'(EDGES - 1));
    assign tx_ready   = (state == IDLE) || (state == CHAIN);
    assign busy       = (state != IDLE);
    assign sclk       = (state == IDLE) ? cfg_cpol : sclk_q;

    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        if (reset) begin
            state  <= IDLE;
            rx_data <= '0;
            mosi   <= 1'b0;
            cs_n   <= '1;
            cnt    <= '0;
            div_q  <= '0;
            ecnt   <= '0;
            tx_sh  <= '0;
            rx_sh  <= '0;
            sel_q  <= '0;
            last_q <= 1'b0;
            cpha_q <= 1'b0;
            sclk_q <= 1'b0;
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
            lb_q   <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, CHAIN: begin
                    if (tx_valid) begin
                        state  <= SETUP;
                        tx_sh  <= tx_data;
                        mosi   <= tx_data[DATA_W-1];
                        last_q <= tx_last;
                        cpha_q <= cfg_cpha;
                        sclk_q <= cfg_cpol;
                        div_q  <= cfg_div;
                        cnt    <= '0;
                        ecnt   <= '0;
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
                        lb_q   <= cfg_loopback;
`endif
                        // a chained word keeps the select held from the first word
                        if (state == IDLE) begin
                            sel_q <= tx_cs_sel;
                            cs_n  <= lb_in ? '1 : cs_dec(tx_cs_sel);
                        end
                    end
                end
                SETUP, XFER: begin
                    if (hp_done) begin
                        cnt    <= '0;
                        sclk_q <= ~sclk_q;
                        ecnt   <= ecnt + 1'b1;
                        if (leading ^ cpha_q) begin
                            rx_sh <= {rx_sh[DATA_W-2:0], din};
                        end else if (!final_edge) begin
                            mosi  <= cpha_q ? tx_sh[DATA_W-1] : tx_sh[DATA_W-2];
                            tx_sh <= tx_sh << 1;
                        end
                        state <= final_edge ? HOLD : XFER;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (hp_done) begin
                        cnt      <= '0;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_sh;
                        if (last_q) begin
                            cs_n  <= '1;
                            state <= IDLE;
                        end else begin
                            state <= CHAIN;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl with a mode-aware SPI slave model.
// Build with SPI_MASTER_CTRL_LOOPBACK_EN to also exercise cfg_loopback.
module tb_spi_master_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_cpol;
    logic       cfg_cpha;
    logic [7:0] cfg_div;
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
    logic       cfg_loopback;
`endif
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [0:0] tx_cs_sel;
    logic       tx_last;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [1:0] cs_n;

    int checks = 0;
    int failures = 0;

    spi_master_ctrl #(.DATA_W(8), .NUM_CS(2), .DIV_W(8)) dut (
        .clk(clk),
        .reset(reset),
        .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha),
        .cfg_div(cfg_div),
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
        .cfg_loopback(cfg_loopback),
`endif
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_data(tx_data),
        .tx_cs_sel(tx_cs_sel),
        .tx_last(tx_last),
        .rx_valid(rx_valid),
        .rx_data(rx_data),
        .busy(busy),
        .sclk(sclk),
        .mosi(mosi),
        .miso(miso),
        .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    // Slave model and bus monitor, evaluated on the falling clk edge.
    int         cyc = 0;
    int         last_chg = 0;
    int         edges_total = 0;
    int         rxv_total = 0;
    int         hp_arr [0:31];
    int         cs_fall [0:1];
    int         cs_rise [0:1];
    logic       prev_sclk = 1'b0;
    logic [1:0] prev_cs = 2'b11;
    logic [7:0] s_rx_word = 8'h00;
    logic [7:0] s_word = 8'h00;
    logic       s_cpha = 1'b0;
    int         s_base = 0;

    initial begin
        for (int i = 0; i < 32; i++) hp_arr[i] = 0;
        for (int i = 0; i < 2; i++) begin
            cs_fall[i] = 0;
            cs_rise[i] = 0;
        end
        miso = 1'b0;
    end

    always @(negedge clk) begin : mon
        int k;
        int bits;
        cyc <= cyc + 1;
        prev_sclk <= sclk;
        prev_cs <= cs_n;
        if (rx_valid) rxv_total <= rxv_total + 1;
        for (int i = 0; i < 2; i++) begin
            if (prev_cs[i] && !cs_n[i]) cs_fall[i] <= cs_fall[i] + 1;
            if (!prev_cs[i] && cs_n[i]) cs_rise[i] <= cs_rise[i] + 1;
        end
        k = edges_total - s_base;
        if (sclk !== prev_sclk) begin
            k = k + 1;
            edges_total <= edges_total + 1;
            last_chg <= cyc;
            if (k >= 1 && k <= 16) begin
                hp_arr[k] <= cyc - last_chg;
                if ((k % 2) == (s_cpha ? 0 : 1))
                    s_rx_word[7 - (k - 1) / 2] <= mosi;
            end
        end
        if (!s_cpha) bits = k / 2;
        else bits = (k + 1) / 2;
        if (!s_cpha && bits <= 7) miso <= s_word[7 - bits];
        else if (s_cpha && bits >= 1 && bits <= 8) miso <= s_word[8 - bits];
        else miso <= 1'b0;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_mode(input logic pol, input logic pha,
                            input logic [7:0] div);
        cfg_cpol = pol;
        cfg_cpha = pha;
        cfg_div = div;
        tick();
        tick();
    endtask

    task automatic do_word(input logic [7:0] d, input logic [0:0] sel,
                           input logic last, input logic [7:0] sw,
                           input logic [7:0] exp_rx, input logic [1:0] exp_cs,
                           input int chg_at, input logic [7:0] chg_div,
                           input string tag);
        logic acc;
        logic seen;
        logic bad;
        s_word = sw;
        s_cpha = cfg_cpha;
        s_base = edges_total;
        tick();
        tx_data = d;
        tx_cs_sel = sel;
        tx_last = last;
        tx_valid = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 50 && !acc; i++) begin
            if (tx_ready) acc = 1'b1;
            tick();
        end
        tx_valid = 1'b0;
        tx_data = ~d;
        chk({tag, "_accept"}, {31'd0, acc}, 32'd1);
        seen = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (i == chg_at) cfg_div = chg_div;
            if (rx_valid) begin
                seen = 1'b1;
            end else begin
                if (cs_n !== exp_cs || !busy) bad = 1'b1;
                tick();
            end
        end
        chk({tag, "_rx_valid"}, {31'd0, seen}, 32'd1);
        chk({tag, "_cs_during"}, {31'd0, bad}, 32'd0);
        chk({tag, "_rx_data"}, {24'd0, rx_data}, {24'd0, exp_rx});
        chk({tag, "_mosi_bits"}, {24'd0, s_rx_word}, {24'd0, d});
        chk({tag, "_edges"}, edges_total - s_base, 32'd16);
        chk({tag, "_cs_end"}, {30'd0, cs_n}, last ? 32'd3 : {30'd0, exp_cs});
        chk({tag, "_busy_end"}, {31'd0, busy}, {31'd0, !last});
        tick();
        chk({tag, "_pulse"}, {31'd0, rx_valid}, 32'd0);
        chk({tag, "_idle_sclk"}, {31'd0, sclk}, {31'd0, cfg_cpol});
    endtask

    initial begin : stim
        int rx0;
        int f0;
        int f1;
        int r1;
        logic hit;
        reset = 1'b1;
        cfg_cpol = 1'b0;
        cfg_cpha = 1'b0;
        cfg_div = 8'd0;
`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
        cfg_loopback = 1'b0;
`endif
        tx_valid = 1'b0;
        tx_data = 8'h00;
        tx_cs_sel = 1'b0;
        tx_last = 1'b0;
        repeat (3) tick();
        chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_cs_n", {30'd0, cs_n}, 32'd3);
        reset = 1'b0;
        tick();
        cfg_cpol = 1'b1;
        tick();
        chk("idle_live_cpol", {31'd0, sclk}, 32'd1);
        cfg_cpol = 1'b0;
        tick();

        set_mode(1'b0, 1'b0, 8'd0);
        do_word(8'hA5, 1'b0, 1'b1, 8'h3C, 8'h3C, 2'b10, -1, 8'd0, "m0");
        chk("m0_hp", hp_arr[8], 32'd1);

        set_mode(1'b0, 1'b1, 8'd3);
        do_word(8'h81, 1'b0, 1'b1, 8'hC3, 8'hC3, 2'b10, -1, 8'd0, "m1");
        chk("m1_hp", hp_arr[8], 32'd4);
        set_mode(1'b1, 1'b0, 8'd3);
        do_word(8'h81, 1'b0, 1'b1, 8'h5A, 8'h5A, 2'b10, -1, 8'd0, "m2");
        chk("m2_hp", hp_arr[9], 32'd4);
        set_mode(1'b1, 1'b1, 8'd3);
        do_word(8'h81, 1'b0, 1'b1, 8'h96, 8'h96, 2'b10, -1, 8'd0, "m3");
        chk("m3_hp", hp_arr[16], 32'd4);

        set_mode(1'b0, 1'b0, 8'd0);
        f0 = cs_fall[0];
        f1 = cs_fall[1];
        r1 = cs_rise[1];
        rx0 = rxv_total;
        do_word(8'h12, 1'b1, 1'b0, 8'hA7, 8'hA7, 2'b01, -1, 8'd0, "ch1");
        chk("ch_ready_chain", {31'd0, tx_ready}, 32'd1);
        do_word(8'h34, 1'b0, 1'b1, 8'h4B, 8'h4B, 2'b01, -1, 8'd0, "ch2");
        chk("ch_cs1_falls", cs_fall[1] - f1, 32'd1);
        chk("ch_cs1_rises", cs_rise[1] - r1, 32'd1);
        chk("ch_cs0_falls", cs_fall[0] - f0, 32'd0);
        chk("ch_rx_pulses", rxv_total - rx0, 32'd2);

        set_mode(1'b0, 1'b0, 8'd3);
        s_word = 8'h00;
        s_cpha = 1'b0;
        s_base = edges_total;
        tick();
        tx_data = 8'hF0;
        tx_cs_sel = 1'b0;
        tx_last = 1'b1;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            if (edges_total - s_base >= 5) hit = 1'b1;
            else tick();
        end
        chk("ra_edge5", {31'd0, hit}, 32'd1);
        chk("ra_ready_busy", {31'd0, tx_ready}, 32'd0);
        rx0 = rxv_total;
        reset = 1'b1;
        tick();
        chk("ra_cs_n", {30'd0, cs_n}, 32'd3);
        chk("ra_busy", {31'd0, busy}, 32'd0);
        chk("ra_tx_ready", {31'd0, tx_ready}, 32'd1);
        chk("ra_rx_data", {24'd0, rx_data}, 32'd0);
        chk("ra_mosi", {31'd0, mosi}, 32'd0);
        chk("ra_sclk", {31'd0, sclk}, 32'd0);
        reset = 1'b0;
        repeat (60) tick();
        chk("ra_no_rx_valid", rxv_total - rx0, 32'd0);

        set_mode(1'b0, 1'b0, 8'd0);
        do_word(8'hC6, 1'b0, 1'b1, 8'h39, 8'h39, 2'b10, 3, 8'd7, "dv1");
        chk("dv1_hp", hp_arr[10], 32'd1);
        do_word(8'h6C, 1'b0, 1'b1, 8'h93, 8'h93, 2'b10, -1, 8'd0, "dv2");
        chk("dv2_hp", hp_arr[10], 32'd8);

`ifdef SPI_MASTER_CTRL_LOOPBACK_EN
        set_mode(1'b0, 1'b0, 8'd1);
        cfg_loopback = 1'b1;
        f0 = cs_fall[0];
        f1 = cs_fall[1];
        do_word(8'h5A, 1'b0, 1'b1, 8'hFF, 8'h5A, 2'b11, -1, 8'd0, "lb");
        chk("lb_cs_falls", (cs_fall[0] - f0) + (cs_fall[1] - f1), 32'd0);
        cfg_loopback = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
